da2_sample_sequencer: RTL and testbench
=======================================

// Module: da2_sample_sequencer
// PURPOSE
//  Upstream feeder for spimaster in the Pmod DA2 path. Accepts paired 12-bit samples (DAC A, DAC B) over valid/ready.
//  On each sample-rate tick, sends two 16-bit DAC121S101 frames (A, then B) through spimaster's start/data_in/busy handshake.
//  chan_sel steers spimaster MOSI to DINA/DINB at top level. Flags underrun, overrun and handshake timeout.
// PARAMETERS
//  RATE_DIV     1000   clk cycles per sample tick (>=2); 50 kHz at 50 MHz clk
//  SPI_CLK_DIV  8'd1   constant driven on spi_clk_div
//  TIMEOUT      64     max cycles in WAIT_HI waiting for spi_busy to rise
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  enable       in   1   1 = tick counter runs
//  s_valid      in   1   sample pair valid
//  s_ready      out  1   holding register empty
//  s_data_a     in   12  DAC A code
//  s_data_b     in   12  DAC B code
//  pd_mode      in   2   DAC121S101 power-down bits, sampled at load
//  spi_start    out  1   1-cycle start pulse to spimaster
//  spi_data     out  16  frame to spimaster data_in
//  spi_clk_div  out  8   to spimaster clk_div (= SPI_CLK_DIV)
//  spi_busy     in   1   spimaster busy
//  chan_sel     out  1   0 = frame for DAC A, 1 = DAC B
//  frame_done   out  1   1-cycle pulse after B frame completes
//  underrun     out  1   1-cycle pulse: tick with holding register empty
//  overrun      out  1   1-cycle pulse: tick while FSM not IDLE
//  timeout_err  out  1   1-cycle pulse: spi_busy never rose
// BEHAVIOUR
//  Reset: all registered outputs 0, spi_data 0, FSM IDLE, chan 0, tick cnt 0, hold empty, work regs A=B=0x000.
//  s_ready = !hold_full && !rst, combinational. Accept on s_valid&&s_ready: latch A, B; hold_full=1.
//  Tick counter: runs while enable; tick on count==RATE_DIV-1, wraps to 0; enable=0 holds count at 0.
//  Frame format: spi_data = {2'b00, pd_q[1:0], work_x[11:0]}; held stable from START through WAIT_LO exit.
//  FSM states: IDLE, START, WAIT_HI, WAIT_LO.
//   IDLE + tick:
//     hold_full  -> copy hold into work, latch pd_mode, clear hold.
//     hold empty -> pulse underrun, resend previous work values.
//     Both cases: chan=0 -> START.
//   START: spi_start=1 for exactly one cycle; clear timeout cnt -> WAIT_HI.
//   WAIT_HI: spi_busy=1 -> WAIT_LO. Cnt reaches TIMEOUT -> pulse timeout_err, treat frame as done (WAIT_LO exit path).
//   WAIT_LO: spi_busy=0 ->
//     chan=0 -> chan=1, START.
//     chan=1 -> pulse frame_done, chan=0, IDLE.
//  Latency: tick cycle -> spi_start high the next cycle. Gap between A done and B spi_start: 1 cycle.
//  Tick in any state but IDLE: pulse overrun; tick discarded. Current pair always completes; never aborted.
//  Accept in the same cycle as IDLE load: impossible; s_ready=0 while full. Load frees hold next cycle.
//  enable dropped mid-pair: pair completes; no further ticks.
//  rst mid-transfer: FSM to IDLE the next edge, spi_start=0, chan_sel=0, hold cleared.
//   Top drives spimaster rst_n = ~rst, so both blocks reset together.
// TESTING
//  1. RATE_DIV=16, pd_mode=00, push A=0x7FF B=0x123 -> spi_data 0x07FF chan_sel=0, then 0x0123 chan_sel=1; one frame_done.
//  2. No push before first tick -> underrun pulse; frames 0x0000 then 0x0000; s_ready stays 1.
//  3. pd_mode=2'b11, A=0xFFF B=0x000 -> frames 0x3FFF then 0x3000; pd change mid-pair not applied until next load.
//  4. spi_busy tied 0 -> timeout_err pulse TIMEOUT cycles after each spi_start; two pulses per pair; FSM back to IDLE.
//  5. RATE_DIV=20 with real spimaster clk_div=1 -> overrun pulses each late tick; every started pair emits both frames.
//  6. Assert rst during WAIT_LO of frame A -> next cycle: spi_start=0, chan_sel=0, s_ready=1; next pair starts with A.

Source files
------------

// File: rtl/da2_sample_sequencer.sv
// da2_sample_sequencer: feeds paired 12-bit DAC codes to spimaster as two
// DAC121S101 frames (A then B) per sample tick, with error pulses.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   enable              runs the sample-rate tick counter
//   s_valid/s_ready     sample-pair handshake (s_data_a, s_data_b)
//   pd_mode             DAC power-down bits, captured when a pair is loaded
//   spi_start/spi_data  start pulse and 16-bit frame to spimaster
//   spi_clk_div         constant SPI clock divider for spimaster
//   spi_busy            spimaster busy
//   chan_sel            0 = frame for DAC A, 1 = frame for DAC B
//   frame_done          pulse after the B frame completes
//   underrun            pulse: tick with no pair waiting
//   overrun             pulse: tick while a pair is still in flight
//   timeout_err         pulse: spi_busy never rose after a start
module da2_sample_sequencer #(
   parameter int unsigned RATE_DIV    = 1000,
   parameter logic [7:0]  SPI_CLK_DIV = 8'd1,
   parameter int unsigned TIMEOUT     = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [11:0] s_data_a,
   input  logic [11:0] s_data_b,
   input  logic [1:0]  pd_mode,
   output logic        spi_start,
   output logic [15:0] spi_data,
   output logic [7:0]  spi_clk_div,
   input  logic        spi_busy,
   output logic        chan_sel,
   output logic        frame_done,
   output logic        underrun,
   output logic        overrun,
   output logic        timeout_err
);

   localparam int CW = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_HI,
      WAIT_LO
   } state_t;

   state_t        state;
   logic [CW-1:0] tick_cnt;
   logic [TW-1:0] to_cnt;
   logic          tick;
   logic          hold_full;
   logic [11:0]   hold_a;
   logic [11:0]   hold_b;
   logic [11:0]   work_a;
   logic [11:0]   work_b;
   logic [1:0]    pd_q;
   logic          accept;
   logic          to_hit;
   logic          frame_end;

   assign spi_clk_div = SPI_CLK_DIV;
   assign s_ready     = !hold_full && !rst;
   assign accept      = s_valid && s_ready;
   assign tick        = enable && (tick_cnt == CW'(RATE_DIV - 1));

   // Compare against TIMEOUT-2 so the registered timeout_err pulse lands
   // exactly TIMEOUT cycles after the matching spi_start pulse.
   assign to_hit    = (to_cnt == TW'(TIMEOUT - 2));
   assign frame_end = !spi_busy &&
                      ((state == WAIT_LO) ||
                       ((state == WAIT_HI) && to_hit));

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         to_cnt      <= '0;
         hold_full   <= 1'b0;
         hold_a      <= '0;
         hold_b      <= '0;
         work_a      <= '0;
         work_b      <= '0;
         pd_q        <= '0;
         spi_start   <= 1'b0;
         spi_data    <= '0;
         chan_sel    <= 1'b0;
         frame_done  <= 1'b0;
         underrun    <= 1'b0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         spi_start   <= 1'b0;
         frame_done  <= 1'b0;
         underrun    <= 1'b0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;

         // s_ready is low while full, so this never meets the IDLE load.
         if (accept) begin
            hold_a    <= s_data_a;
            hold_b    <= s_data_b;
            hold_full <= 1'b1;
         end

         if (tick && (state != IDLE)) begin
            overrun <= 1'b1;
         end

         unique case (state)
            IDLE: begin
               if (tick) begin
                  if (hold_full) begin
                     work_a    <= hold_a;
                     work_b    <= hold_b;
                     pd_q      <= pd_mode;
                     hold_full <= 1'b0;
                     spi_data  <= {2'b00, pd_mode, hold_a};
                  end else begin
                     // Nothing new: repeat the last pair.
                     underrun <= 1'b1;
                     spi_data <= {2'b00, pd_q, work_a};
                  end
                  chan_sel  <= 1'b0;
                  spi_start <= 1'b1;
                  state     <= START;
               end
            end
            START: begin
               to_cnt <= '0;
               state  <= WAIT_HI;
            end
            WAIT_HI: begin
               if (spi_busy) begin
                  state <= WAIT_LO;
               end else if (to_hit) begin
                  timeout_err <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            WAIT_LO: begin
            end
         endcase

         // Shared exit for a finished frame, whether busy fell or timed out.
         if (frame_end) begin
            if (!chan_sel) begin
               chan_sel  <= 1'b1;
               spi_data  <= {2'b00, pd_q, work_b};
               spi_start <= 1'b1;
               state     <= START;
            end else begin
               chan_sel   <= 1'b0;
               frame_done <= 1'b1;
               state      <= IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_da2_sample_sequencer.sv
// tb_da2_sample_sequencer: drives sample pairs against a spimaster busy
// model and scores every frame, pulse count and timing corner.
module tb_da2_sample_sequencer;

   localparam int RD = 16;
   localparam int TO = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        s_valid;
   logic        s_ready;
   logic [11:0] s_data_a;
   logic [11:0] s_data_b;
   logic [1:0]  pd_mode;
   logic        spi_start;
   logic [15:0] spi_data;
   logic [7:0]  spi_clk_div;
   logic        spi_busy = 1'b0;
   logic        chan_sel;
   logic        frame_done;
   logic        underrun;
   logic        overrun;
   logic        timeout_err;

   always #5 clk = ~clk;

   da2_sample_sequencer #(
      .RATE_DIV   (RD),
      .SPI_CLK_DIV(8'd1),
      .TIMEOUT    (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data_a   (s_data_a),
      .s_data_b   (s_data_b),
      .pd_mode    (pd_mode),
      .spi_start  (spi_start),
      .spi_data   (spi_data),
      .spi_clk_div(spi_clk_div),
      .spi_busy   (spi_busy),
      .chan_sel   (chan_sel),
      .frame_done (frame_done),
      .underrun   (underrun),
      .overrun    (overrun),
      .timeout_err(timeout_err)
   );

   typedef struct {
      logic [11:0] a;
      logic [11:0] b;
      logic [1:0]  pd;
      logic [1:0]  pd_mid;
      logic [15:0] ea;
      logic [15:0] eb;
   } vec_t;

   vec_t        vt[4];
   logic [16:0] sb[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          last_start = 0;
   int          n_done = 0;
   int          n_under = 0;
   int          n_over = 0;
   int          n_to = 0;
   int          busy_len = 3;
   int          bcnt = 0;
   bit          tie_low = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // spimaster stand-in: busy rises after a start and stays up busy_len cycles.
   always @(negedge clk) begin
      if (rst) begin
         spi_busy = 1'b0;
         bcnt     = 0;
      end else if (spi_start && !tie_low) begin
         spi_busy = 1'b1;
         bcnt     = busy_len;
      end else if (spi_busy) begin
         bcnt--;
         if (bcnt == 0) spi_busy = 1'b0;
      end
   end

   // Scoreboard side: pop an expected {chan, frame} on every start.
   always @(negedge clk) begin
      logic [16:0] e;
      cyc++;
      if (timeout_err) begin
         n_to++;
         chk("timeout_gap", cyc - last_start, TO);
      end
      if (spi_start) begin
         last_start = cyc;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_start actual=%0h expected=none",
                     {chan_sel, spi_data});
         end else begin
            e = sb.pop_front();
            chk("frame", {15'd0, chan_sel, spi_data}, {15'd0, e});
         end
      end
      if (frame_done) n_done++;
      if (underrun) n_under++;
      if (overrun) n_over++;
   end

   task automatic wait_for(input int which, input string name);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if ((which == 0) ? spi_start : frame_done) return;
      end
      checks++;
      failures++;
      $display("FAIL %s actual=no_event expected=event", name);
   endtask

   task automatic run_pair(input vec_t v, input int exp_over,
                           input int exp_to);
      int d0, u0, o0, t0;
      @(negedge clk);
      chk("ready_empty", s_ready, 1);
      s_valid  = 1'b1;
      s_data_a = v.a;
      s_data_b = v.b;
      pd_mode  = v.pd;
      sb.push_back({1'b0, v.ea});
      sb.push_back({1'b1, v.eb});
      @(negedge clk);
      s_valid = 1'b0;
      chk("ready_full", s_ready, 0);
      d0 = n_done;
      u0 = n_under;
      o0 = n_over;
      t0 = n_to;
      enable = 1'b1;
      wait_for(0, "start_a");
      pd_mode = v.pd_mid;
      wait_for(1, "frame_done");
      enable = 1'b0;
      repeat (4) @(negedge clk);
      chk("done_cnt", n_done - d0, 1);
      chk("no_underrun", n_under - u0, 0);
      chk("overrun_cnt", n_over - o0, exp_over);
      chk("timeout_cnt", n_to - t0, exp_to);
      chk("sb_drained", sb.size(), 0);
      chk("ready_after", s_ready, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout actual=stuck expected=finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      vec_t v;
      int u0, d0;
      vt[0] = '{12'h7FF, 12'h123, 2'b00, 2'b00, 16'h07FF, 16'h0123};
      vt[1] = '{12'hFFF, 12'h000, 2'b11, 2'b11, 16'h3FFF, 16'h3000};
      vt[2] = '{12'h111, 12'h222, 2'b01, 2'b11, 16'h1111, 16'h1222};
      vt[3] = '{12'hABC, 12'h555, 2'b10, 2'b10, 16'h2ABC, 16'h2555};

      rst      = 1'b1;
      enable   = 1'b0;
      s_valid  = 1'b0;
      s_data_a = '0;
      s_data_b = '0;
      pd_mode  = 2'b00;
      repeat (3) @(negedge clk);
      chk("ready_in_rst", s_ready, 0);
      rst = 1'b0;
      #1;
      chk("rst_ready", s_ready, 1);
      chk("rst_start", spi_start, 0);
      chk("rst_data", spi_data, 16'h0000);
      chk("rst_chan", chan_sel, 0);
      chk("rst_clkdiv", spi_clk_div, 8'd1);
      chk("rst_flags", {frame_done, underrun, overrun, timeout_err}, 0);

      // Empty hold at the first tick: underrun, zero frames resent.
      sb.push_back({1'b0, 16'h0000});
      sb.push_back({1'b1, 16'h0000});
      u0 = n_under;
      d0 = n_done;
      enable = 1'b1;
      wait_for(0, "start_under");
      chk("ready_under", s_ready, 1);
      wait_for(1, "done_under");
      enable = 1'b0;
      repeat (4) @(negedge clk);
      chk("underrun_cnt", n_under - u0, 1);
      chk("done_under_cnt", n_done - d0, 1);
      chk("ready_under_end", s_ready, 1);

      for (int i = 0; i < 4; i++) run_pair(vt[i], 0, 0);

      // Underrun after loads: the last pair and its pd bits go out again.
      sb.push_back({1'b0, 16'h2ABC});
      sb.push_back({1'b1, 16'h2555});
      u0 = n_under;
      enable = 1'b1;
      wait_for(1, "done_resend");
      enable = 1'b0;
      repeat (4) @(negedge clk);
      chk("resend_underrun", n_under - u0, 1);
      chk("resend_sb", sb.size(), 0);

      // spimaster never goes busy: one timeout per frame, pair still closes.
      tie_low = 1'b1;
      v = '{12'h456, 12'h789, 2'b00, 2'b00, 16'h0456, 16'h0789};
      run_pair(v, 0, 2);
      tie_low = 1'b0;

      // Slow transfers: the tick mid-pair is flagged and dropped.
      busy_len = 12;
      v = '{12'h0F0, 12'h00F, 2'b01, 2'b01, 16'h10F0, 16'h100F};
      run_pair(v, 1, 0);

      // Reset in the A frame's WAIT_LO with a second pair held.
      busy_len = 6;
      @(negedge clk);
      s_valid  = 1'b1;
      s_data_a = 12'h321;
      s_data_b = 12'h654;
      pd_mode  = 2'b00;
      sb.push_back({1'b0, 16'h0321});
      @(negedge clk);
      s_valid = 1'b0;
      enable  = 1'b1;
      wait_for(0, "start_rst");
      @(negedge clk);
      chk("ready_reload", s_ready, 1);
      s_valid  = 1'b1;
      s_data_a = 12'h777;
      s_data_b = 12'h888;
      @(negedge clk);
      s_valid = 1'b0;
      chk("ready_held", s_ready, 0);
      @(negedge clk);
      rst    = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      chk("rst_mid_start", spi_start, 0);
      chk("rst_mid_chan", chan_sel, 0);
      chk("rst_mid_data", spi_data, 16'h0000);
      chk("rst_mid_sb", sb.size(), 0);
      rst = 1'b0;
      #1;
      chk("rst_mid_ready", s_ready, 1);
      busy_len = 3;
      repeat (3) @(negedge clk);
      v = '{12'h5A5, 12'hA5A, 2'b00, 2'b00, 16'h05A5, 16'h0A5A};
      run_pair(v, 0, 0);

      chk("sb_final", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
